// File: rtl/ps_mux_pkg.sv
// rtl/ps_mux_pkg.sv - shared constants, state encoding and timestamp formatting for the program-stream mux
//
// Contents:
//   START_CODE / PACK_ID      start-code prefix and pack-header stream id
//   TS_PREFIX / TS_NONE       PTS prefix nibble and the "no timestamp" byte
//   *_BYTES                   byte counts of the pack, PES, STD and PTS fields
//   state_e                   header generator states
//   fmt_ts()                  33-bit timestamp -> 40-bit field with marker bits
package ps_mux_pkg;

    localparam logic [23:0] START_CODE = 24'h000001;
    localparam logic [7:0]  PACK_ID    = 8'hBA;
    localparam logic [3:0]  TS_PREFIX  = 4'b0010;
    localparam logic [7:0]  TS_NONE    = 8'h0F;

    localparam int PACK_BYTES = 12;
    localparam int PES_BYTES  = 6;
    localparam int STD_BYTES  = 2;
    localparam int PTS_BYTES  = 5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PACK = 3'd1,
        ST_PES  = 3'd2,
        ST_STD  = 3'd3,
        ST_TS   = 3'd4
    } state_e;

    // The same layout serves the SCR inside the pack header and the PTS field.
    function automatic logic [39:0] fmt_ts(input logic [3:0] prefix, input logic [32:0] ts);
        return {prefix, ts[32:30], 1'b1, ts[29:22], ts[21:15], 1'b1,
                ts[14:7], ts[6:0], 1'b1};
    endfunction

endpackage

// File: rtl/ps_header_gen.sv
// rtl/ps_header_gen.sv - pack header and video PES header byte generator for the misc FIFO
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   clk_en              global clock enable
//   req_*               request: payload length, PTS enable/value, pack-header enable
//   scr, mux_rate       pack-header fields, sampled at accept
//   misc_afull          misc FIFO nearly full; holds emission
//   misc_out, misc_wr   header byte and its write strobe
//   len_err             one-cycle pulse when a request's PES length overflows
//   req_ready, busy     idle / not idle
// Configuration macro: PS_STD_BUFFER_EN inserts the 2-byte STD buffer field after the PES header.
module ps_header_gen #(
    parameter logic [7:0]  STREAM_ID = 8'hE0,
    parameter logic        STD_SCALE = 1'b1,
    parameter logic [12:0] STD_SIZE  = 13'd46
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_len,
    input  logic        req_pts_en,
    input  logic [32:0] req_pts,
    input  logic        req_pack,
    input  logic [32:0] scr,
    input  logic [21:0] mux_rate,
    input  logic        misc_afull,
    output logic [7:0]  misc_out,
    output logic        misc_wr,
    output logic        len_err,
    output logic        busy
);
    import ps_mux_pkg::*;

`ifdef PS_STD_BUFFER_EN
    localparam logic [16:0] STD_H = 17'd2;
`else
    localparam logic [16:0] STD_H = 17'd0;
`endif

    state_e      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  misc_out_q, misc_out_d;
    logic        misc_wr_q, misc_wr_d;
    logic        len_err_q, len_err_d;
    logic [15:0] plen_q, plen_d;
    logic        pts_en_q, pts_en_d;
    logic [32:0] pts_q, pts_d;
    logic [32:0] scr_q, scr_d;
    logic [21:0] mux_q, mux_d;

    logic        accept;
    logic [16:0] plen_calc;
    logic [39:0] scr_fmt, pts_fmt;
    logic [3:0]  last_idx;
    logic [7:0]  cur_byte;
    state_e      next_state;

    function automatic logic [7:0] ts_byte(input logic [39:0] v, input logic [3:0] k);
        case (k)
            4'd0:    return v[39:32];
            4'd1:    return v[31:24];
            4'd2:    return v[23:16];
            4'd3:    return v[15:8];
            default: return v[7:0];
        endcase
    endfunction

    assign accept    = clk_en && req_valid && (state_q == ST_IDLE);
    assign plen_calc = {1'b0, req_len} + (req_pts_en ? 17'd5 : 17'd1) + STD_H;
    assign scr_fmt   = fmt_ts(TS_PREFIX, scr_q);
    assign pts_fmt   = fmt_ts(TS_PREFIX, pts_q);

    always_comb begin
        last_idx   = 4'd0;
        next_state = ST_IDLE;
        case (state_q)
            ST_PACK: begin
                last_idx   = 4'(PACK_BYTES - 1);
                next_state = ST_PES;
            end
            ST_PES: begin
                last_idx   = 4'(PES_BYTES - 1);
`ifdef PS_STD_BUFFER_EN
                next_state = ST_STD;
`else
                next_state = ST_TS;
`endif
            end
            ST_STD: begin
                last_idx   = 4'(STD_BYTES - 1);
                next_state = ST_TS;
            end
            ST_TS: begin
                last_idx   = pts_en_q ? 4'(PTS_BYTES - 1) : 4'd0;
                next_state = ST_IDLE;
            end
            default: begin
                last_idx   = 4'd0;
                next_state = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        cur_byte = 8'h00;
        case (state_q)
            ST_PACK: begin
                case (idx_q)
                    4'd0:    cur_byte = START_CODE[23:16];
                    4'd1:    cur_byte = START_CODE[15:8];
                    4'd2:    cur_byte = START_CODE[7:0];
                    4'd3:    cur_byte = PACK_ID;
                    4'd9:    cur_byte = {1'b1, mux_q[21:15]};
                    4'd10:   cur_byte = mux_q[14:7];
                    4'd11:   cur_byte = {mux_q[6:0], 1'b1};
                    default: cur_byte = ts_byte(scr_fmt, idx_q - 4'd4);
                endcase
            end
            ST_PES: begin
                case (idx_q)
                    4'd0:    cur_byte = START_CODE[23:16];
                    4'd1:    cur_byte = START_CODE[15:8];
                    4'd2:    cur_byte = START_CODE[7:0];
                    4'd3:    cur_byte = STREAM_ID;
                    4'd4:    cur_byte = plen_q[15:8];
                    default: cur_byte = plen_q[7:0];
                endcase
            end
            // Unreachable unless the STD field is enabled; next_state never selects it otherwise.
            ST_STD:  cur_byte = (idx_q == 4'd0) ? {2'b01, STD_SCALE, STD_SIZE[12:8]} : STD_SIZE[7:0];
            ST_TS:   cur_byte = pts_en_q ? ts_byte(pts_fmt, idx_q) : TS_NONE;
            default: cur_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        misc_out_d = misc_out_q;
        misc_wr_d  = 1'b0;
        len_err_d  = 1'b0;
        plen_d     = plen_q;
        pts_en_d   = pts_en_q;
        pts_d      = pts_q;
        scr_d      = scr_q;
        mux_d      = mux_q;
        if (accept) begin
            pts_en_d = req_pts_en;
            pts_d    = req_pts;
            scr_d    = scr;
            mux_d    = mux_rate;
            plen_d   = plen_calc[15:0];
            idx_d    = 4'd0;
            if (plen_calc[16]) begin
                len_err_d = 1'b1;
            end else begin
                state_d = req_pack ? ST_PACK : ST_PES;
            end
        end else if (clk_en && !misc_afull && state_q != ST_IDLE) begin
            misc_out_d = cur_byte;
            misc_wr_d  = 1'b1;
            if (idx_q == last_idx) begin
                idx_d   = 4'd0;
                state_d = next_state;
            end else begin
                idx_d = idx_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= 4'd0;
            misc_out_q <= 8'h00;
            misc_wr_q  <= 1'b0;
            len_err_q  <= 1'b0;
            plen_q     <= 16'd0;
            pts_en_q   <= 1'b0;
            pts_q      <= 33'd0;
            scr_q      <= 33'd0;
            mux_q      <= 22'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            misc_out_q <= misc_out_d;
            misc_wr_q  <= misc_wr_d;
            len_err_q  <= len_err_d;
            plen_q     <= plen_d;
            pts_en_q   <= pts_en_d;
            pts_q      <= pts_d;
            scr_q      <= scr_d;
            mux_q      <= mux_d;
        end
    end

    assign misc_out  = misc_out_q;
    assign misc_wr   = misc_wr_q;
    assign len_err   = len_err_q;
    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ps_header_gen.sv
// tb/tb_ps_header_gen.sv - self-checking bench for ps_header_gen against a byte-list model
module tb_ps_header_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_en = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_len = '0;
    logic        req_pts_en = 1'b0;
    logic [32:0] req_pts = '0;
    logic        req_pack = 1'b0;
    logic [32:0] scr = '0;
    logic [21:0] mux_rate = '0;
    logic        misc_afull = 1'b0;
    logic [7:0]  misc_out;
    logic        misc_wr;
    logic        len_err;
    logic        busy;

    ps_header_gen dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .req_valid(req_valid), .req_ready(req_ready), .req_len(req_len),
        .req_pts_en(req_pts_en), .req_pts(req_pts), .req_pack(req_pack),
        .scr(scr), .mux_rate(mux_rate), .misc_afull(misc_afull),
        .misc_out(misc_out), .misc_wr(misc_wr), .len_err(len_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int         vectors = 0;
    int         errors  = 0;
    logic [7:0] exp_q[$];
    logic [7:0] cap_q[$];
    logic [7:0] lit_q[$];
    logic [7:0] e_byte;
    bit         err_ok = 1'b0;
    bit         ovf;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    // Expected byte stream straight from the header layout rules.
    task automatic model(input logic [15:0] len, input bit pts_en, input logic [32:0] pts,
                         input bit pack, input logic [32:0] s, input logic [21:0] m,
                         output bit overflow);
        int          plen;
        logic [15:0] p16;
        logic [39:0] t40;
        plen = int'(len) + (pts_en ? 5 : 1);
`ifdef PS_STD_BUFFER_EN
        plen = plen + 2;
`endif
        overflow = (plen > 65535);
        if (overflow) return;
        p16 = plen[15:0];
        if (pack) begin
            exp_q.push_back(8'h00); exp_q.push_back(8'h00);
            exp_q.push_back(8'h01); exp_q.push_back(8'hBA);
            t40 = {4'b0010, s[32:30], 1'b1, s[29:22], s[21:15], 1'b1, s[14:7], s[6:0], 1'b1};
            for (int k = 0; k < 5; k++) exp_q.push_back(t40[39-8*k -: 8]);
            exp_q.push_back({1'b1, m[21:15]});
            exp_q.push_back(m[14:7]);
            exp_q.push_back({m[6:0], 1'b1});
        end
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        exp_q.push_back(8'h01); exp_q.push_back(8'hE0);
        exp_q.push_back(p16[15:8]); exp_q.push_back(p16[7:0]);
`ifdef PS_STD_BUFFER_EN
        exp_q.push_back(8'h60); exp_q.push_back(8'h2E);
`endif
        if (pts_en) begin
            t40 = {4'b0010, pts[32:30], 1'b1, pts[29:22], pts[21:15], 1'b1, pts[14:7], pts[6:0], 1'b1};
            for (int k = 0; k < 5; k++) exp_q.push_back(t40[39-8*k -: 8]);
        end else begin
            exp_q.push_back(8'h0F);
        end
    endtask

    // Every write is checked against the model and recorded for literal checks.
    always @(negedge clk) begin
        if (misc_wr) begin
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got %02h, want no write", misc_out);
            end else begin
                e_byte = exp_q.pop_front();
                if (misc_out !== e_byte) begin
                    errors++;
                    $display("FAIL misc_byte: got %02h, want %02h", misc_out, e_byte);
                end
            end
            cap_q.push_back(misc_out);
        end
        if (len_err && !err_ok) begin
            vectors++;
            errors++;
            $display("FAIL spurious_len_err: got 1, want 0");
        end
    end

    task automatic send(input logic [15:0] len, input bit pts_en, input logic [32:0] pts,
                        input bit pack, input logic [32:0] s, input logic [21:0] m,
                        output bit overflow);
        int n = 0;
        @(negedge clk); #1;
        while (!req_ready && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        chk("ready_before_send", req_ready, 1);
        cap_q.delete();
        model(len, pts_en, pts, pack, s, m, overflow);
        err_ok     = overflow;
        req_len    = len;
        req_pts_en = pts_en;
        req_pts    = pts;
        req_pack   = pack;
        scr        = s;
        mux_rate   = m;
        req_valid  = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (overflow) begin
            chk("len_err_pulse", len_err, 1);
            chk("ready_after_reject", req_ready, 1);
            @(posedge clk); #1;
            chk("len_err_clear", len_err, 0);
            err_ok = 1'b0;
        end else begin
            chk("busy_after_accept", busy, 1);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_q.size() != 0 || !req_ready) && n < 300) begin
            @(negedge clk); #1;
            n++;
        end
        chk("header_complete", exp_q.size() == 0, 1);
        chk("ready_after_header", req_ready, 1);
    endtask

    task automatic wait_caps(input int k);
        int n = 0;
        while (cap_q.size() < k && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        chk("reached_byte_count", cap_q.size() >= k, 1);
    endtask

    task automatic check_lit(input string name);
        bit ok;
        ok = (cap_q.size() == lit_q.size());
        for (int i = 0; ok && i < lit_q.size(); i++)
            if (cap_q[i] !== lit_q[i]) ok = 1'b0;
        vectors++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d bytes %p, want %0d bytes %p", name, cap_q.size(), cap_q,
                     lit_q.size(), lit_q);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_misc_out", misc_out, 8'h00);
        chk("rst_misc_wr", misc_wr, 0);
        chk("rst_len_err", len_err, 0);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        @(negedge clk); #1;
        rst = 1'b0;

`ifndef PS_STD_BUFFER_EN
        // Plain PES header, with first-write latency check.
        send(16'd100, 0, 33'd0, 0, 33'd0, 22'd0, ovf);
        chk("latency_no_write_yet", misc_wr, 0);
        @(posedge clk); #1;
        chk("latency_first_write", misc_wr, 1);
        chk("latency_first_byte", misc_out, 8'h00);
        wait_done();
        lit_q = '{8'h00, 8'h00, 8'h01, 8'hE0, 8'h00, 8'h65, 8'h0F};
        check_lit("pes_len100");

        send(16'd16, 1, 33'd0, 0, 33'd0, 22'd0, ovf);
        wait_done();
        lit_q = '{8'h00, 8'h00, 8'h01, 8'hE0, 8'h00, 8'h15, 8'h21, 8'h00, 8'h01, 8'h00, 8'h01};
        check_lit("pes_pts0");

        send(16'd1, 0, 33'd0, 1, 33'd0, 22'd1, ovf);
        wait_done();
        lit_q = '{8'h00, 8'h00, 8'h01, 8'hBA, 8'h21, 8'h00, 8'h01, 8'h00, 8'h01, 8'h80, 8'h00,
                  8'h03, 8'h00, 8'h00, 8'h01, 8'hE0, 8'h00, 8'h02, 8'h0F};
        check_lit("pack_pes");
`else
        send(16'd10, 0, 33'd0, 0, 33'd0, 22'd0, ovf);
        wait_done();
        lit_q = '{8'h00, 8'h00, 8'h01, 8'hE0, 8'h00, 8'h0D, 8'h60, 8'h2E, 8'h0F};
        check_lit("std_len10");
`endif

        // Non-trivial SCR, mux rate and PTS bit patterns, checked by the model.
        send(16'd500, 1, 33'h1_2345_6789, 1, 33'h0_ABCD_EF01, 22'h2A5A5A, ovf);
        wait_done();
        send(16'd7, 1, 33'h1_FFFF_FFFF, 1, 33'h1_FFFF_FFFF, 22'h3FFFFF, ovf);
        wait_done();

        // Stall during the PES bytes: FIFO almost full, then clock enable low.
        send(16'd100, 0, 33'd0, 0, 33'd0, 22'd0, ovf);
        wait_caps(2);
        misc_afull = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("no_write_afull", misc_wr, 0);
        end
        misc_afull = 1'b0;
        clk_en     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("no_write_clk_en_low", misc_wr, 0);
        end
        clk_en = 1'b1;
        wait_done();
`ifndef PS_STD_BUFFER_EN
        lit_q = '{8'h00, 8'h00, 8'h01, 8'hE0, 8'h00, 8'h65, 8'h0F};
        check_lit("pes_after_stall");
`endif

        // Length overflow boundary.
        send(16'd65531, 1, 33'd0, 0, 33'd0, 22'd0, ovf);
        chk("model_overflow_65531", ovf, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("ready_after_overflow", req_ready, 1);
        chk("no_writes_after_overflow", cap_q.size(), 0);
`ifndef PS_STD_BUFFER_EN
        send(16'd65530, 1, 33'd0, 0, 33'd0, 22'd0, ovf);
        wait_done();
        lit_q = '{8'h00, 8'h00, 8'h01, 8'hE0, 8'hFF, 8'hFF, 8'h21, 8'h00, 8'h01, 8'h00, 8'h01};
        check_lit("pes_len_ffff");
`endif

        // Asynchronous reset in the middle of a pack header.
        send(16'd50, 0, 33'd0, 1, 33'h0_1234_5678, 22'd99, ovf);
        wait_caps(6);
        rst = 1'b1;
        #1;
        chk("mid_rst_misc_wr", misc_wr, 0);
        chk("mid_rst_misc_out", misc_out, 8'h00);
        chk("mid_rst_ready", req_ready, 1);
        chk("mid_rst_busy", busy, 0);
        exp_q.delete();
        @(negedge clk); #1;
        rst = 1'b0;
        send(16'd100, 0, 33'd0, 0, 33'd0, 22'd0, ovf);
        wait_done();
`ifndef PS_STD_BUFFER_EN
        lit_q = '{8'h00, 8'h00, 8'h01, 8'hE0, 8'h00, 8'h65, 8'h0F};
        check_lit("pes_after_reset");
`endif

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
